pipe_stage_skid_register: RTL and testbench
===========================================

Name: pipe_stage_skid_register

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers.
- Carries one opaque payload vector (the packed stage control and data bundle) between any two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure stalls the upstream stage through a registered ready rather than a combinational path.
- Synchronous flush kills all in-flight entries; used between decode/execute, execute/memory, and similar stage pairs.

Parameters:
- PAYLOAD_WIDTH, 128, width of the packed stage bundle (control fields, register addresses, immediates, PC).
- CNT_WIDTH, 32, width of the performance counters (optional feature only).

Ports:
- clk_i  input  1  stage clock, all state updates on rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; kills every held entry and any entry offered this cycle.
- valid_i  input  1  upstream has a payload this cycle.
- ready_o  output  1  stage can accept; registered, equals "skid entry empty".
- payload_i  input  PAYLOAD_WIDTH  upstream bundle.
- valid_o  output  1  output entry valid.
- ready_i  input  1  downstream accepts this cycle.
- payload_o  output  PAYLOAD_WIDTH  output bundle, driven directly from the main register.
- occupancy_o  output  2  number of held entries (0..2).

Behaviour:
- Handshake definitions:
  - in_fire = valid_i & ready_o & ~flush_i.
  - out_fire = valid_o & ready_i.
- Storage: main register (drives payload_o) and skid register, each with its own valid bit.
- Occupancy states:
  - EMPTY: main invalid, skid invalid.
  - FULL: main valid, skid invalid.
  - SKID: main valid, skid valid.
- EMPTY:
  - in_fire -> main <= payload_i; go to FULL.
  - Otherwise stay in EMPTY.
- FULL:
  - in_fire & out_fire -> main <= payload_i; stay in FULL.
  - in_fire & ~out_fire -> skid <= payload_i; go to SKID.
  - ~in_fire & out_fire -> go to EMPTY.
  - Neither -> hold.
- SKID:
  - ready_o = 0, so in_fire is impossible.
  - out_fire -> main <= skid; go to FULL.
  - Otherwise hold.
- flush_i = 1 overrides every transition: next state is EMPTY.
  - A simultaneous valid_i is dropped.
  - A simultaneous out_fire still completes downstream in that cycle.
- Output encodings:
  - ready_o = ~skid_valid.
  - valid_o = main_valid.
  - occupancy_o = main_valid + skid_valid; it is 0 in EMPTY, 1 in FULL, 2 in SKID.
- Output rules:
  - Once valid_o is high, payload_o and valid_o stay stable until out_fire or flush.
  - valid_o never drops without out_fire except on flush.
  - payload_o is not cleared by flush and holds its last value while valid_o = 0; consumers gate on valid_o.
- Latency and throughput:
  - Latency 1 cycle from in_fire to valid_o.
  - Full throughput of 1 transfer/cycle when ready_i stays high.
  - No combinational path from ready_i to ready_o, or from valid_i to valid_o.
- Reset (asynchronous, reset_n_i low):
  - valid_o = 0, ready_o = 1, occupancy_o = 0.
  - payload_o = 0, skid payload = 0, counters = 0.
  - Reset asserted mid-operation discards both entries immediately, without waiting for a clock edge.
  - First acceptance is possible on the first rising edge after reset_n_i deasserts.
- Ordering: strict FIFO; the skid entry is never emitted before the main entry.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cycles_o (CNT_WIDTH): increments each cycle with valid_o & ~ready_i.
  - bubble_cycles_o (CNT_WIDTH): increments each cycle with ~valid_o & ~flush_i.
- Both counters:
  - Wrap modulo 2^CNT_WIDTH.
  - Reset to 0 on reset_n_i only; flush does not clear them.
- When undefined, neither port nor their logic exists; block behaviour is otherwise identical.

Test Plan:
- Reset then stream: reset_n_i low 3 cycles, then payload_i = 0x01..0x08 with valid_i = 1 and ready_i = 1 -> valid_o is 0 until cycle 1 after the first in_fire, then payload_o shows 0x01..0x08 on consecutive cycles; ready_o stays 1; occupancy_o = 1.
- Back-pressure: stream 0xA0, 0xA1, 0xA2 while ready_i = 0 -> occupancy goes 1 then 2; ready_o = 0 from the cycle after 0xA1 is accepted; 0xA2 is held upstream. Raising ready_i then yields 0xA0, 0xA1, 0xA2 in order, with no loss or duplication.
- Flush in SKID state: two entries 0xB0 and 0xB1 held, flush_i = 1 with valid_i = 1 and payload 0xB2 -> next cycle valid_o = 0, occupancy_o = 0, ready_o = 1; 0xB2 never appears at the output.
- Flush concurrent with out_fire: FULL with 0xC0, ready_i = 1, flush_i = 1 -> 0xC0 counted as transferred that cycle; EMPTY next cycle.
- Asynchronous reset mid-stream: SKID state, reset_n_i pulsed low between clock edges -> valid_o = 0 and ready_o = 1 before the next edge; payload_o = 0.
- PIPE_STAGE_PERF_CNT_EN: 5 cycles with valid_o = 1 and ready_i = 0, then 3 idle cycles -> stall_cycles_o = 5 and bubble_cycles_o = 3; a subsequent flush leaves both unchanged.

Source files
------------

// File: rtl/pipe_stage_skid_register.sv
// rtl/pipe_stage_skid_register.sv - valid/ready pipeline stage register with 2-entry skid buffer (optional PIPE_STAGE_PERF_CNT_EN)
module pipe_stage_skid_register #(
    parameter int PAYLOAD_WIDTH = 128,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [PAYLOAD_WIDTH-1:0] payload_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [PAYLOAD_WIDTH-1:0] payload_o,
`ifdef PIPE_STAGE_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0]     stall_cycles_o,
    output logic [CNT_WIDTH-1:0]     bubble_cycles_o,
`endif
    output logic [1:0]               occupancy_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [PAYLOAD_WIDTH-1:0] main_q;
    logic [PAYLOAD_WIDTH-1:0] skid_q;
    logic                     main_valid;
    logic                     skid_valid;
    logic                     in_fire;
    logic                     out_fire;
    logic                     load_main_in;
    logic                     load_main_skid;
    logic                     load_skid_in;

    // Valid bits are decoded from the state; ready_o depends only on registered state
    assign main_valid  = (state_q != ST_EMPTY);
    assign skid_valid  = (state_q == ST_SKID);
    assign ready_o     = ~skid_valid;
    assign valid_o     = main_valid;
    assign payload_o   = main_q;
    assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};
    assign in_fire     = valid_i & ready_o & ~flush_i;
    assign out_fire    = valid_o & ready_i;

    // State register; reset discards both entries without waiting for a clock
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and register load enables; flush wins over every transition
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_d      = ST_FULL;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid_in = 1'b1;
                    state_d      = ST_SKID;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush keeps payload_o at its last value, so no register loads happen
        if (flush_i) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    // Main payload register feeding payload_o
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            main_q <= '0;
        end else if (load_main_in) begin
            main_q <= payload_i;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
    end

    // Skid payload register catching the entry accepted while downstream stalls
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            skid_q <= '0;
        end else if (load_skid_in) begin
            skid_q <= payload_i;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;
    logic [CNT_WIDTH-1:0] bubble_q;

    assign stall_cycles_o  = stall_q;
    assign bubble_cycles_o = bubble_q;

    // Stall and bubble counters; wrap naturally and survive flush
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (valid_o && !ready_i) begin
                stall_q <= stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (!valid_o && !flush_i) begin
                bubble_q <= bubble_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    // Counter width is only meaningful with the counters built in
    logic unused_cnt_width;
    assign unused_cnt_width = |CNT_WIDTH;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_register.sv
// tb/tb_pipe_stage_skid_register.sv - self-checking bench for pipe_stage_skid_register
module tb_pipe_stage_skid_register;

    localparam int W  = 128;
    localparam int CW = 32;

    logic          clk_i;
    logic          reset_n_i;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  payload_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  payload_o;
    logic [1:0]    occupancy_o;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CW-1:0] stall_cycles_o;
    logic [CW-1:0] bubble_cycles_o;
`endif

    pipe_stage_skid_register #(
        .PAYLOAD_WIDTH(W),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .payload_i(payload_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .payload_o(payload_o),
`ifdef PIPE_STAGE_PERF_CNT_EN
        .stall_cycles_o(stall_cycles_o),
        .bubble_cycles_o(bubble_cycles_o),
`endif
        .occupancy_o(occupancy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a FIFO of at most two held entries
    logic [W-1:0]  mq[$];
    logic [W-1:0]  mpout;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_bubble;
    logic [W-1:0]  got[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpout    = '0;
        m_stall  = '0;
        m_bubble = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_o"}, W'(valid_o), W'(mq.size() > 0));
        chk({tag, ".ready_o"}, W'(ready_o), W'(mq.size() < 2));
        chk({tag, ".occupancy_o"}, W'(occupancy_o), W'(mq.size()));
        chk({tag, ".payload_o"}, payload_o, mpout);
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk({tag, ".stall"}, W'(stall_cycles_o), W'(m_stall));
        chk({tag, ".bubble"}, W'(bubble_cycles_o), W'(m_bubble));
`endif
    endtask

    // One clock cycle: drive inputs, log downstream transfers, advance model, check
    task automatic step(input string tag, input logic v, input logic [W-1:0] p,
                        input logic r, input logic f);
        int  sz;
        logic in_f;
        logic out_f;
        valid_i   = v;
        payload_i = p;
        ready_i   = r;
        flush_i   = f;
        #1;
        if (valid_o && ready_i) got.push_back(payload_o);
        @(posedge clk_i);
        sz    = mq.size();
        in_f  = v && (sz < 2) && !f;
        out_f = (sz > 0) && r;
        if (sz > 0 && !r) m_stall = m_stall + 1'b1;
        if (sz == 0 && !f) m_bubble = m_bubble + 1'b1;
        if (out_f) void'(mq.pop_front());
        if (f) mq.delete();
        else if (in_f) mq.push_back(p);
        if (mq.size() > 0) mpout = mq[0];
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] rp;
        reset_n_i = 1'b0;
        flush_i   = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        payload_i = '0;
        model_reset();

        // Reset held for three cycles
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst.valid_o", W'(valid_o), W'(1'b0));
        chk("rst.ready_o", W'(ready_o), W'(1'b1));
        chk("rst.occupancy_o", W'(occupancy_o), W'(0));
        chk("rst.payload_o", payload_o, W'(0));
        reset_n_i = 1'b1;

        // Streaming at full throughput
        for (int i = 1; i <= 8; i++) begin
            step("stream", 1'b1, W'(i), 1'b1, 1'b0);
            chk("stream.payload", payload_o, W'(i));
            chk("stream.occ", W'(occupancy_o), W'(1));
            chk("stream.ready", W'(ready_o), W'(1'b1));
        end
        step("drain", 1'b0, '0, 1'b1, 1'b0);
        chk("stream.count", W'(got.size()), W'(8));

        // Back-pressure fills the skid entry
        got.delete();
        step("bp0", 1'b1, W'('hA0), 1'b0, 1'b0);
        chk("bp.occ1", W'(occupancy_o), W'(1));
        step("bp1", 1'b1, W'('hA1), 1'b0, 1'b0);
        chk("bp.occ2", W'(occupancy_o), W'(2));
        chk("bp.ready_low", W'(ready_o), W'(1'b0));
        step("bp2", 1'b1, W'('hA2), 1'b0, 1'b0);
        chk("bp.held_main", payload_o, W'('hA0));
        step("bp3", 1'b1, W'('hA2), 1'b1, 1'b0);
        step("bp4", 1'b1, W'('hA2), 1'b1, 1'b0);
        step("bp5", 1'b0, '0, 1'b1, 1'b0);
        chk("bp.count", W'(got.size()), W'(3));
        if (got.size() == 3) begin
            chk("bp.order0", got[0], W'('hA0));
            chk("bp.order1", got[1], W'('hA1));
            chk("bp.order2", got[2], W'('hA2));
        end

        // Flush while two entries are held, with a new offer on the same cycle
        got.delete();
        step("fs0", 1'b1, W'('hB0), 1'b0, 1'b0);
        step("fs1", 1'b1, W'('hB1), 1'b0, 1'b0);
        step("fs2", 1'b1, W'('hB2), 1'b0, 1'b1);
        chk("fs.valid_o", W'(valid_o), W'(1'b0));
        chk("fs.occ", W'(occupancy_o), W'(0));
        chk("fs.ready_o", W'(ready_o), W'(1'b1));
        step("fs3", 1'b0, '0, 1'b1, 1'b0);
        step("fs4", 1'b0, '0, 1'b1, 1'b0);
        chk("fs.nothing_out", W'(got.size()), W'(0));

        // Flush concurrent with a downstream transfer
        got.delete();
        step("fo0", 1'b1, W'('hC0), 1'b0, 1'b0);
        step("fo1", 1'b0, '0, 1'b1, 1'b1);
        chk("fo.count", W'(got.size()), W'(1));
        if (got.size() == 1) chk("fo.payload", got[0], W'('hC0));
        chk("fo.valid_o", W'(valid_o), W'(1'b0));

        // Asynchronous reset between edges while in SKID
        step("ar0", 1'b1, W'('hD0), 1'b0, 1'b0);
        step("ar1", 1'b1, W'('hD1), 1'b0, 1'b0);
        #1 reset_n_i = 1'b0;
        #1;
        chk("ar.valid_o", W'(valid_o), W'(1'b0));
        chk("ar.ready_o", W'(ready_o), W'(1'b1));
        chk("ar.occ", W'(occupancy_o), W'(0));
        chk("ar.payload_o", payload_o, W'(0));
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        model_reset();
        check_all("ar.post");
        step("ar.first", 1'b1, W'('hE0), 1'b1, 1'b0);
        chk("ar.first_accept", payload_o, W'('hE0));

`ifdef PIPE_STAGE_PERF_CNT_EN
        // Counters: from a fresh reset, one bubble, five stalls, one transfer, three idles, a flush
        #1 reset_n_i = 1'b0;
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        model_reset();
        step("pc.load", 1'b1, W'('hF0), 1'b0, 1'b0);
        repeat (5) step("pc.stall", 1'b0, '0, 1'b0, 1'b0);
        step("pc.out", 1'b0, '0, 1'b1, 1'b0);
        repeat (3) step("pc.idle", 1'b0, '0, 1'b0, 1'b0);
        chk("pc.stall5", W'(stall_cycles_o), W'(5));
        chk("pc.bubble", W'(bubble_cycles_o), W'(4));
        step("pc.flush", 1'b0, '0, 1'b0, 1'b1);
        chk("pc.stall_kept", W'(stall_cycles_o), W'(5));
        chk("pc.bubble_kept", W'(bubble_cycles_o), W'(4));
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            step("rand", 1'($urandom_range(0, 3) != 0), rp,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
